// File: rtl/encoder_fifo.sv
// encoder_fifo: packs five consecutive AXI4-Stream samples into one wide word
// and buffers the packed groups in a first-word-fall-through FIFO for the
// LPC encoder core. Start-of-frame / end-of-line markers ride with each group.
module encoder_fifo #(
    parameter int DEPTH      = 128,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET_N,
    input  logic [DATA_WIDTH-1:0]     TDATA,
    input  logic                      TVALID,
    output logic                      TREADY,
    input  logic                      TUSER,
    input  logic                      TLAST,
    input  logic                      RD_EN,
    output logic [5*DATA_WIDTH-1:0]   DATA_OUT,
    output logic                      LAST_OUT,
    output logic                      USER_OUT,
    output logic                      EMPTY
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = 5 * DATA_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Packer state: slot of the next sample, four earlier samples, sticky user flag.
    logic [2:0]            slot_q, slot_d;
    logic [DATA_WIDTH-1:0] hold_q [4];
    logic [DATA_WIDTH-1:0] hold_d [4];
    logic                  user_q, user_d;

    // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;

    // Entry layout: {user, last, packed group}.
    logic [OW+1:0]         mem [DEPTH];
    logic [OW+1:0]         head;
    logic [OW-1:0]         pack_word;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Handshake and FIFO status flags, all derived from registered state.
    always_comb begin
        EMPTY  = (count_q == '0);
        TREADY = ARESET_N && (count_q != FULL_CNT);
        accept = TVALID && TREADY;
        push   = accept && ((slot_q == 3'd4) || TLAST);
        pop    = RD_EN && !EMPTY;
    end

    // Assemble the group being written: held samples, then the current one, zeros below.
    always_comb begin
        pack_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < slot_q) pack_word[OW-1-i*DATA_WIDTH -: DATA_WIDTH] = hold_q[i];
        end
        for (int i = 0; i < 5; i++) begin
            if (3'(i) == slot_q) pack_word[OW-1-i*DATA_WIDTH -: DATA_WIDTH] = TDATA;
        end
    end

    // Next-state logic for the packer and FIFO pointers/count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        slot_d   = slot_q;
        hold_d   = hold_q;
        user_d   = user_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (accept) begin
            if (push) begin
                slot_d = 3'd0;
                user_d = 1'b0;
            end else begin
                hold_d[slot_q[1:0]] = TDATA;
                slot_d              = slot_q + 3'd1;
                user_d              = user_q | TUSER;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!ARESET_N) begin
            slot_q   <= 3'd0;
            user_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
        end else begin
            slot_q   <= slot_d;
            user_q   <= user_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage write; a completed group lands at the tail.
    always_ff @(posedge ACLK) begin
        // NOTE: storage is not reset; count and pointers already mark every entry invalid.
        if (push) mem[wr_ptr_q] <= {user_q | TUSER, TLAST, pack_word};
    end

    // Fall-through head; outputs forced to zero while empty.
    always_comb begin
        head     = mem[rd_ptr_q];
        DATA_OUT = EMPTY ? '0   : head[OW-1:0];
        LAST_OUT = EMPTY ? 1'b0 : head[OW];
        USER_OUT = EMPTY ? 1'b0 : head[OW+1];
    end

endmodule

// File: tb/tb_encoder_fifo.sv
// tb_encoder_fifo: directed vector table plus hand-written sequences for
// long lines, full FIFO, simultaneous push/pop and mid-group reset.
module tb_encoder_fifo;

    logic        ACLK = 1'b0;
    logic        ARESET_N;
    logic [15:0] TDATA;
    logic        TVALID;
    logic        TREADY;
    logic        TUSER;
    logic        TLAST;
    logic        RD_EN;
    logic [79:0] DATA_OUT;
    logic        LAST_OUT;
    logic        USER_OUT;
    logic        EMPTY;

    int checks   = 0;
    int failures = 0;

    encoder_fifo #(.DEPTH(128), .DATA_WIDTH(16)) dut (
        .ACLK     (ACLK),
        .ARESET_N (ARESET_N),
        .TDATA    (TDATA),
        .TVALID   (TVALID),
        .TREADY   (TREADY),
        .TUSER    (TUSER),
        .TLAST    (TLAST),
        .RD_EN    (RD_EN),
        .DATA_OUT (DATA_OUT),
        .LAST_OUT (LAST_OUT),
        .USER_OUT (USER_OUT),
        .EMPTY    (EMPTY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tuser;
        logic        tlast;
        logic        rd_en;
        logic        exp_empty;
        logic        exp_tready;
        logic        exp_last;
        logic        exp_user;
        logic [79:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic u,
                         input logic l, input logic r);
        TVALID = v; TDATA = d; TUSER = u; TLAST = l; RD_EN = r;
    endtask

    // Expected full group of five consecutive values starting at base.
    function automatic logic [79:0] grp(input int base);
        logic [79:0] r;
        for (int i = 0; i < 5; i++) r[79-16*i -: 16] = 16'(base + i);
        return r;
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[4]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                     80'h0001_0002_0003_0004_0005};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[6]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[7]  = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[8]  = '{1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                     80'hAAAA_BBBB_CCCC_0000_0000};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
        vecs[11] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                     80'h1234_0000_0000_0000_0000};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};

        // Reset held for three cycles with traffic offered.
        ARESET_N = 1'b0;
        drive(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1);
        repeat (3) step();
        check("reset_outputs", {EMPTY, TREADY, LAST_OUT, USER_OUT, DATA_OUT},
              {1'b1, 1'b0, 1'b0, 1'b0, 80'h0});
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        ARESET_N = 1'b1;
        step();
        check("release_tready", {EMPTY, TREADY}, 2'b11);

        // Vector table: single group, partial flush, empty pop, one-sample flush.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].tvalid, vecs[i].tdata, vecs[i].tuser, vecs[i].tlast, vecs[i].rd_en);
            step();
            check($sformatf("vec%0d", i),
                  {EMPTY, TREADY, LAST_OUT, USER_OUT, DATA_OUT},
                  {vecs[i].exp_empty, vecs[i].exp_tready, vecs[i].exp_last,
                   vecs[i].exp_user, vecs[i].exp_data});
        end

        // Line of 1920 samples with continuous reads: 384 groups, last flag only on the final one.
        for (int j = 0; j < 1920; j++) begin
            drive(1'b1, 16'(j), 1'b0, (j == 1919), 1'b1);
            step();
            if (j % 5 == 4)
                check($sformatf("line_grp%0d", j / 5),
                      {EMPTY, LAST_OUT, USER_OUT, DATA_OUT},
                      {1'b0, (j == 1919), 1'b0, grp(j - 4)});
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        check("line_drained", EMPTY, 1'b1);

        // Fill to 128 entries with no reads.
        for (int j = 0; j < 640; j++) begin
            drive(1'b1, 16'(j), 1'b0, 1'b0, 1'b0);
            if (j == 639) check("full_tready_before", TREADY, 1'b1);
            step();
        end
        check("full_tready_low", TREADY, 1'b0);
        drive(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        check("full_stall", {TREADY, EMPTY, LAST_OUT, USER_OUT, DATA_OUT},
              {1'b0, 1'b0, 1'b0, 1'b0, grp(0)});
        drive(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1);
        step();
        check("full_pop_tready", {TREADY, DATA_OUT}, {1'b1, grp(5)});
        for (int j = 640; j < 645; j++) begin
            drive(1'b1, 16'(j), 1'b0, 1'b0, 1'b0);
            step();
        end
        check("refull_tready_low", TREADY, 1'b0);
        for (int g = 1; g <= 128; g++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            check($sformatf("drain_grp%0d", g), {EMPTY, LAST_OUT, USER_OUT, DATA_OUT},
                  {1'b0, 1'b0, 1'b0, grp(5 * g)});
            step();
        end
        check("drain_empty", {EMPTY, TREADY}, 2'b11);

        // Three entries stored, fourth group completes on the same edge as a pop.
        for (int j = 0; j < 19; j++) begin
            drive(1'b1, 16'(16'h0200 + j), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 16'h0213, 1'b0, 1'b0, 1'b1);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            check($sformatf("simul_head%0d", k), {EMPTY, DATA_OUT},
                  {1'b0, grp(16'h0200 + 5 * k)});
            step();
        end
        check("simul_empty", EMPTY, 1'b1);

        // Reset with a stored entry and a partial group pending.
        for (int j = 0; j < 7; j++) begin
            drive(1'b1, 16'(16'h0300 + j), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        ARESET_N = 1'b0;
        step();
        check("midreset_outputs", {EMPTY, TREADY, LAST_OUT, USER_OUT, DATA_OUT},
              {1'b1, 1'b0, 1'b0, 1'b0, 80'h0});
        ARESET_N = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 16'(16'h0500 + j), 1'b0, 1'b0, 1'b0);
            step();
        end
        check("midreset_fresh_group", {EMPTY, DATA_OUT}, {1'b0, grp(16'h0500)});
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        check("midreset_single_entry", EMPTY, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
